mouse_cursor_overlay: RTL
=========================

// Module: mouse_cursor_overlay
// PURPOSE
//  Reader side of the mouse-cursor bitmap ROM: walks the VGA raster, drives the
//  ROM's 5-bit line_number and consumes its 8-bit line_code row bitmap. Overlays
//  cursor pixels onto the incoming RGB stream at the latched mouse position.
//  Sits between the VGA timing/pixel source and the DAC output register.
// PARAMETERS
//  H_ACTIVE      640      visible pixels per line; mouse_x clamped to H_ACTIVE-1
//  V_ACTIVE      480      visible lines per frame; mouse_y clamped to V_ACTIVE-1
//  CURSOR_H      11       bitmap rows used (ROM rows 0..CURSOR_H-1)
//  CURSOR_COLOR  12'hFFF  RGB444 value for cursor pixels
// PORTS
//  clk           in   1   pixel clock
//  rst_n         in   1   synchronous reset, active low
//  mouse_x       in   10  new cursor column (tip = top-left of bitmap)
//  mouse_y       in   10  new cursor row
//  pos_valid     in   1   1-cycle strobe: mouse_x/y valid
//  cursor_en     in   1   0 = cursor hidden, pixels pass through
//  frame_start   in   1   1-cycle strobe at start of vertical blank
//  h_count       in   10  current raster column
//  v_count       in   10  current raster row
//  video_on      in   1   raster in visible area
//  pixel_in      in   12  RGB444 background pixel, aligned with h/v_count
//  line_number   out  5   row index to bitmap ROM (registered)
//  line_code     in   8   ROM row bitmap, combinational from line_number
//  pixel_out     out  12  RGB444 output pixel
//  video_on_out  out  1   video_on delayed to align with pixel_out
//  cursor_hit    out  1   pixel_out is a cursor pixel this cycle
// BEHAVIOUR
//  Reset: line_number=0, pixel_out=0, video_on_out=0, cursor_hit=0,
//   shadow/active pos=0, state=HIDDEN.
//  Position: pos_valid loads shadow_x/y (clamped). Active pos copied from shadow
//   only on frame_start -> no tearing mid-frame. pos_valid and frame_start in the
//   same cycle: the new values go to shadow AND active (bypass).
//  FSM (2-bit): HIDDEN -> PENDING on pos_valid; PENDING -> SHOWN on frame_start;
//   SHOWN stays SHOWN (updates via shadow). Any state -> HIDDEN when cursor_en=0;
//   on cursor_en re-asserting, -> PENDING if a position was ever received, else
//   HIDDEN. Only SHOWN permits hits.
//  Stage 1 (registered): dx = h_count - act_x, dy = v_count - act_y (11-bit,
//   borrow = outside). in_box = no borrow && dx<8 && dy<CURSOR_H && video_on &&
//   state==SHOWN. line_number <= in_box ? dy[4:0] : 0; col_d1 <= dx[2:0].
//   pixel_in, video_on, in_box delayed into stage-1 regs.
//  Stage 2 (registered): hit = in_box_d1 && line_code[col_d1] (bit0 = leftmost
//   column, bit7 = rightmost). pixel_out <= !video_on_d1 ? 0 : hit ?
//   CURSOR_COLOR : pixel_d1. cursor_hit <= hit; video_on_out <= video_on_d1.
//  Latency: 2 clk from h_count/v_count/pixel_in to pixel_out/cursor_hit.
//  Edges: cursor clipped at right/bottom screen edges (no wrap to next line or
//   top); h_count < act_x never hits (borrow). Reset mid-frame: pipeline and
//   position cleared; cursor hidden until next pos_valid + frame_start.
// TESTING
//  1 pos (100,50) valid, frame_start, raster (100,50) -> 2 clk later pixel_out
//    =12'hFFF, cursor_hit=1; (101,50) -> pixel_in passthrough (row0=0x01).
//  2 Row 7 at pos (100,50): v=57, h=100..107 -> 8 consecutive hits; h=108 no hit;
//    row 11 (v=61) -> no hit, line_number=0.
//  3 pos_valid (200,200) mid-frame -> cursor stays at old pos until frame_start,
//    then hits at (200,200); same-cycle pos_valid+frame_start -> used at once.
//  4 mouse_x=700,mouse_y=600 -> clamped (639,479); only column 639 row 479 hit,
//    no hit at h=0 on any line.
//  5 cursor_en=0 -> cursor_hit=0, pixel_out=pixel_in delayed 2; video_on=0 ->
//    pixel_out=0 even inside box.
//  6 rst_n=0 for 1 clk while SHOWN -> all outputs 0 next clk; no hits until
//    new pos_valid and frame_start.

Source files
------------

// File: rtl/mouse_cursor_overlay.sv
// Mouse cursor overlay: two-stage pipeline that reads the cursor bitmap ROM
// row for the current raster position and replaces background pixels with the
// cursor colour wherever the bitmap bit is set. The cursor position is
// double-buffered so that it only changes between frames.
module mouse_cursor_overlay #(
  parameter int          H_ACTIVE     = 640,
  parameter int          V_ACTIVE     = 480,
  parameter int          CURSOR_H     = 11,
  parameter logic [11:0] CURSOR_COLOR = 12'hFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  mouse_x,
  input  logic [9:0]  mouse_y,
  input  logic        pos_valid,
  input  logic        cursor_en,
  input  logic        frame_start,
  input  logic [9:0]  h_count,
  input  logic [9:0]  v_count,
  input  logic        video_on,
  input  logic [11:0] pixel_in,
  output logic [4:0]  line_number,
  input  logic [7:0]  line_code,
  output logic [11:0] pixel_out,
  output logic        video_on_out,
  output logic        cursor_hit,
  output logic [1:0]  dbg_state
);

  // Handshake: pos_valid and frame_start are single-cycle strobes with no
  // ready/backpressure; the block accepts a strobe on every cycle in which it
  // is high, and a new pos_valid simply overwrites the shadow position.

  typedef enum logic [1:0] {
    ST_HIDDEN  = 2'd0,
    ST_PENDING = 2'd1,
    ST_SHOWN   = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic        r_pos_seen;
  logic [9:0]  r_shadow_x;
  logic [9:0]  r_shadow_y;
  logic [9:0]  r_act_x;
  logic [9:0]  r_act_y;

  logic [9:0]  w_clamp_x;
  logic [9:0]  w_clamp_y;
  logic [10:0] w_dx;
  logic [10:0] w_dy;
  logic        w_in_box;
  logic        w_hit;

  logic        r_in_box_d1;
  logic [2:0]  r_col_d1;
  logic [11:0] r_pixel_d1;
  logic        r_video_d1;

  localparam logic [9:0] X_MAX = 10'(H_ACTIVE - 1);
  localparam logic [9:0] Y_MAX = 10'(V_ACTIVE - 1);

  assign dbg_state = r_state;

  // Clamp the incoming mouse position to the visible area.
  always_comb begin
    w_clamp_x = (mouse_x > X_MAX) ? X_MAX : mouse_x;
    w_clamp_y = (mouse_y > Y_MAX) ? Y_MAX : mouse_y;
  end

  // Shadow position follows pos_valid; active position updates only at frame
  // start, taking a same-cycle pos_valid directly so it is not a frame late.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_shadow_x <= '0;
      r_shadow_y <= '0;
      r_act_x    <= '0;
      r_act_y    <= '0;
      r_pos_seen <= 1'b0;
    end else begin
      if (pos_valid) begin
        r_shadow_x <= w_clamp_x;
        r_shadow_y <= w_clamp_y;
        r_pos_seen <= 1'b1;
      end
      if (frame_start) begin
        r_act_x <= pos_valid ? w_clamp_x : r_shadow_x;
        r_act_y <= pos_valid ? w_clamp_y : r_shadow_y;
      end
    end
  end

  // Visibility state register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_HIDDEN;
    else        r_state <= w_state_next;
  end

  // Visibility next state: disabling always hides; a cursor is shown only
  // after a position is known and a frame boundary has been crossed.
  always_comb begin
    w_state_next = r_state;
    if (!cursor_en) begin
      w_state_next = ST_HIDDEN;
    end else begin
      case (r_state)
        ST_HIDDEN:  if (pos_valid || r_pos_seen) w_state_next = ST_PENDING;
        ST_PENDING: if (frame_start)             w_state_next = ST_SHOWN;
        ST_SHOWN:   w_state_next = ST_SHOWN;
        default:    w_state_next = ST_HIDDEN;
      endcase
    end
  end

  // Raster offset from the cursor tip; bit 10 is the borrow, meaning the
  // raster is left of / above the cursor, which also prevents wrap-around.
  always_comb begin
    w_dx     = {1'b0, h_count} - {1'b0, r_act_x};
    w_dy     = {1'b0, v_count} - {1'b0, r_act_y};
    w_in_box = !w_dx[10] && !w_dy[10] &&
               (w_dx[9:0] < 10'd8) && (w_dy[9:0] < 10'(CURSOR_H)) &&
               video_on && (r_state == ST_SHOWN);
  end

  // Stage 1: address the bitmap ROM and delay the pixel stream to match it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      line_number <= '0;
      r_col_d1    <= '0;
      r_in_box_d1 <= 1'b0;
      r_pixel_d1  <= '0;
      r_video_d1  <= 1'b0;
    end else begin
      line_number <= w_in_box ? w_dy[4:0] : 5'd0;
      r_col_d1    <= w_dx[2:0];
      r_in_box_d1 <= w_in_box;
      r_pixel_d1  <= pixel_in;
      r_video_d1  <= video_on;
    end
  end

  // Bitmap bit 0 is the leftmost cursor column.
  assign w_hit = r_in_box_d1 && line_code[r_col_d1];

  // Stage 2: select cursor colour, background, or black outside active video.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pixel_out    <= '0;
      cursor_hit   <= 1'b0;
      video_on_out <= 1'b0;
    end else begin
      pixel_out    <= !r_video_d1 ? 12'h000 : (w_hit ? CURSOR_COLOR : r_pixel_d1);
      cursor_hit   <= w_hit;
      video_on_out <= r_video_d1;
    end
  end

endmodule
